// File: rtl/pc_seq_pkg.sv
// Shared definitions for the step sequencer: instruction field positions,
// opcode encodings and the controller state enumeration.
package pc_seq_pkg;

  // Instruction word layout: [15:12] opcode, [11:0] operand
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned OPND_MSB = 11;
  localparam int unsigned OPND_LSB = 0;
  localparam int unsigned OPND_W   = OPND_MSB - OPND_LSB + 1;

  // Opcodes; 5..15 are undefined and execute as NOP
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_SETV = 4'h1;
  localparam logic [3:0] OP_WAIT = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FETCH,
    ST_EXEC,
    ST_WAITT,
    ST_HALTED
  } seq_state_t;

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the registered 50 Hz divider output.
// Produces a single-cycle tick_out for each rising edge of level_in.
//   clk_100m : system clock
//   rst      : asynchronous active-high reset
//   level_in : slow level sampled as data
//   tick_out : one-cycle pulse per rising edge of level_in
module tick_edge_det (
  input  logic clk_100m,
  input  logic rst,
  input  logic level_in,
  output logic tick_out
);

  logic level_q;
  logic armed;

  // armed stays low after reset until level_in has been seen low, so a level
  // that is already high when reset releases does not produce a tick.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_q <= level_in;
      if (!level_in) armed <= 1'b1;
    end
  end

  assign tick_out = armed & level_in & ~level_q;

endmodule

// File: rtl/pc_step_sequencer.sv
// Tick-paced program sequencer driving a valve control word.
// Executes one instruction from a synchronous ROM per 50 Hz tick.
//   clk_100m  : system clock
//   rst       : asynchronous active-high reset
//   clk_50Hz  : registered divided clock, sampled as data
//   run       : start pulse (honoured in IDLE/HALTED)
//   stop      : abort pulse (honoured in every state)
//   imem_addr : ROM read address (equals pc)
//   imem_data : ROM word, valid one cycle after imem_addr
//   pc        : program counter
//   valve_out : registered valve control word
//   busy      : high in RUN/FETCH/EXEC/WAITT
//   halted    : high in HALTED
module pc_step_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned VALVE_W = 12
) (
  input  logic               clk_100m,
  input  logic               rst,
  input  logic               clk_50Hz,
  input  logic               run,
  input  logic               stop,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_data,
  output logic [PC_W-1:0]    pc,
  output logic [VALVE_W-1:0] valve_out,
  output logic               busy,
  output logic               halted
);

  seq_state_t        state;
  logic [OPND_W-1:0] wait_cnt;
  logic              tick;

  logic [3:0]        opcode;
  logic [OPND_W-1:0] operand;
  logic [PC_W-1:0]   pc_inc;

  tick_edge_det u_tick (
    .clk_100m (clk_100m),
    .rst      (rst),
    .level_in (clk_50Hz),
    .tick_out (tick)
  );

  assign opcode    = imem_data[OPC_MSB:OPC_LSB];
  assign operand   = imem_data[OPND_MSB:OPND_LSB];
  assign pc_inc    = pc + PC_W'(1);
  assign imem_addr = pc;

  // busy/halted are registered alongside state, so every transition below
  // sets them to match the state being entered.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      valve_out <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else if (stop) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_HALTED: begin
          if (run) begin
            pc     <= '0;
            state  <= ST_RUN;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        ST_RUN: begin
          if (tick) state <= ST_FETCH;
        end
        ST_FETCH: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_RUN;
          case (opcode)
            OP_SETV: begin
              valve_out <= VALVE_W'(operand);
              pc        <= pc_inc;
            end
            OP_WAIT: begin
              if (operand == '0) begin
                pc <= pc_inc;
              end else begin
                wait_cnt <= operand;
                state    <= ST_WAITT;
              end
            end
            OP_JMP: begin
              pc <= PC_W'(operand);
            end
            OP_HALT: begin
              state  <= ST_HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: begin
              pc <= pc_inc;
            end
          endcase
        end
        ST_WAITT: begin
          if (tick) begin
            wait_cnt <= wait_cnt - OPND_W'(1);
            if (wait_cnt == OPND_W'(1)) begin
              pc    <= pc_inc;
              state <= ST_RUN;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_step_sequencer.sv
module tb_pc_step_sequencer;

  logic        clk_100m = 1'b0;
  logic        rst      = 1'b0;
  logic        clk_50Hz = 1'b0;
  logic        run      = 1'b0;
  logic        stop     = 1'b0;

  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_data;
  logic [11:0] valve_out;
  logic        busy, halted;

  logic [1:0]  imem_addr2, pc2;
  logic [15:0] imem_data2;
  logic [11:0] valve_out2;
  logic        busy2, halted2;

  logic [15:0] rom  [0:255];
  logic [15:0] rom2 [0:3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_100m = ~clk_100m;

  always @(posedge clk_100m) imem_data  <= rom[imem_addr];
  always @(posedge clk_100m) imem_data2 <= rom2[imem_addr2];

  pc_step_sequencer #(.PC_W(8), .VALVE_W(12)) dut (
    .clk_100m (clk_100m), .rst (rst), .clk_50Hz (clk_50Hz),
    .run (run), .stop (stop),
    .imem_addr (imem_addr), .imem_data (imem_data),
    .pc (pc), .valve_out (valve_out), .busy (busy), .halted (halted)
  );

  pc_step_sequencer #(.PC_W(2), .VALVE_W(12)) dut2 (
    .clk_100m (clk_100m), .rst (rst), .clk_50Hz (clk_50Hz),
    .run (run), .stop (stop),
    .imem_addr (imem_addr2), .imem_data (imem_data2),
    .pc (pc2), .valve_out (valve_out2), .busy (busy2), .halted (halted2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  // clk_50Hz high for 4 cycles, low for 4 cycles: one tick, fully executed
  task automatic do_tick();
    clk_50Hz = 1'b1;
    cyc(4);
    clk_50Hz = 1'b0;
    cyc(4);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    cyc(1);
    run = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;
    rom_clear();
    #1 rst = 1'b1;
    cyc(2);

    // reset state
    check_eq("rst_pc",     32'(pc), 32'h0);
    check_eq("rst_addr",   32'(imem_addr), 32'h0);
    check_eq("rst_valve",  32'(valve_out), 32'h0);
    check_eq("rst_busy",   32'(busy), 32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    rst = 1'b0;
    cyc(2);

    // SETV 0x0A5, NOP, HALT
    rom_clear();
    rom[0] = 16'h10A5; rom[1] = 16'h0000; rom[2] = 16'h4000;
    pulse_run();
    check_eq("t1_busy_run", 32'(busy), 32'h1);
    do_tick();
    check_eq("t1_valve", 32'(valve_out), 32'h0A5);
    check_eq("t1_pc1",   32'(pc), 32'h1);
    do_tick();
    check_eq("t1_pc2",   32'(pc), 32'h2);
    do_tick();
    check_eq("t1_halted", 32'(halted), 32'h1);
    check_eq("t1_busy_h", 32'(busy), 32'h0);
    check_eq("t1_pc_h",   32'(pc), 32'h2);
    // run from HALTED restarts at 0, valve held
    pulse_run();
    check_eq("t1_rs_pc",    32'(pc), 32'h0);
    check_eq("t1_rs_busy",  32'(busy), 32'h1);
    check_eq("t1_rs_halt",  32'(halted), 32'h0);
    check_eq("t1_rs_valve", 32'(valve_out), 32'h0A5);
    do_tick(); do_tick(); do_tick();
    check_eq("t1_halt2", 32'(halted), 32'h1);
    // stop and run together in HALTED: stop wins
    stop = 1'b1; run = 1'b1;
    cyc(1);
    stop = 1'b0; run = 1'b0;
    cyc(1);
    check_eq("sr_halted", 32'(halted), 32'h0);
    check_eq("sr_busy",   32'(busy), 32'h0);
    check_eq("sr_pc",     32'(pc), 32'h2);

    // WAIT 3, SETV 0x001
    apply_reset();
    rom_clear();
    rom[0] = 16'h2003; rom[1] = 16'h1001;
    pulse_run();
    for (int t = 1; t <= 3; t++) begin
      do_tick();
      check_eq($sformatf("t2_pc_tick%0d", t), 32'(pc), 32'h0);
    end
    do_tick();
    check_eq("t2_pc_tick4",  32'(pc), 32'h1);
    check_eq("t2_valve_t4",  32'(valve_out), 32'h0);
    do_tick();
    check_eq("t2_valve_t5",  32'(valve_out), 32'h001);

    // SETV 0x00F, JMP 0
    apply_reset();
    rom_clear();
    rom[0] = 16'h100F; rom[1] = 16'h3000;
    pulse_run();
    for (int t = 1; t <= 6; t++) begin
      do_tick();
      check_eq($sformatf("t3_pc_tick%0d", t), 32'(pc), (t % 2 == 1) ? 32'h1 : 32'h0);
      if (t == 1) begin
        // run while RUN is ignored
        pulse_run();
        cyc(2);
        check_eq("t3_run_ign", 32'(pc), 32'h1);
      end
    end
    check_eq("t3_valve", 32'(valve_out), 32'h00F);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_eq("t3_stop_busy",  32'(busy), 32'h0);
    check_eq("t3_stop_valve", 32'(valve_out), 32'h00F);

    // PC_W=2, all NOP: wrap from 3 to 0
    apply_reset();
    rom_clear();
    pulse_run();
    for (int t = 1; t <= 5; t++) begin
      do_tick();
      check_eq($sformatf("t4_pc2_tick%0d", t), 32'(pc2), 32'((t) % 4));
    end

    // stop coinciding with a tick while in WAITT
    apply_reset();
    rom_clear();
    rom[0] = 16'h2003; rom[1] = 16'h0000;
    pulse_run();
    do_tick();
    check_eq("t5_wait_busy", 32'(busy), 32'h1);
    clk_50Hz = 1'b1; stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_eq("t5_stop_busy", 32'(busy), 32'h0);
    check_eq("t5_stop_pc",   32'(pc), 32'h0);
    cyc(3);
    clk_50Hz = 1'b0;
    cyc(4);
    do_tick();
    check_eq("t5_idle_busy", 32'(busy), 32'h0);
    pulse_run();
    check_eq("t5_rerun_pc",   32'(pc), 32'h0);
    check_eq("t5_rerun_busy", 32'(busy), 32'h1);
    for (int t = 1; t <= 4; t++) do_tick();
    check_eq("t5_after_wait", 32'(pc), 32'h1);

    // async reset in RUN with clk_50Hz high; no tick on release
    apply_reset();
    rom_clear();
    rom[0] = 16'h103C;
    pulse_run();
    do_tick();
    check_eq("t6_valve", 32'(valve_out), 32'h03C);
    clk_50Hz = 1'b1;
    cyc(5);
    check_eq("t6_pc_pre", 32'(pc), 32'h2);
    #3 rst = 1'b1;
    #1;
    check_eq("t6_rst_pc",     32'(pc), 32'h0);
    check_eq("t6_rst_valve",  32'(valve_out), 32'h0);
    check_eq("t6_rst_busy",   32'(busy), 32'h0);
    check_eq("t6_rst_halted", 32'(halted), 32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    pulse_run();
    cyc(4);
    check_eq("t6_no_tick_pc", 32'(pc), 32'h0);
    check_eq("t6_no_tick_v",  32'(valve_out), 32'h0);
    clk_50Hz = 1'b0;
    cyc(4);
    do_tick();
    check_eq("t6_first_tick_pc", 32'(pc), 32'h1);
    check_eq("t6_first_tick_v",  32'(valve_out), 32'h03C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
